// File: rtl/sram_multi_port_arbiter_pkg.sv
// sram_multi_port_arbiter_pkg: shared state encodings, SRAM pin levels and index-width helper
package sram_multi_port_arbiter_pkg;
    typedef enum logic [1:0] {ST_ARB, ST_DRAIN, ST_LOAD} state_t;
    localparam logic SRAM_ACTIVE = 1'b0;
    localparam logic SRAM_IDLE = 1'b1;
    function automatic int idx_width(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/sram_multi_port_arbiter_if.sv
// sram_multi_port_arbiter_if: loader and processor-master bus of the shared SRAM arbiter
interface sram_multi_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_MASTERS = 2
);
    logic                             load_req;
    logic                             load_cen;
    logic                             load_wen;
    logic [ADDR_WIDTH-1:0]            load_a;
    logic [DATA_WIDTH-1:0]            load_d;
    logic [DATA_WIDTH-1:0]            load_q;
    logic                             load_active;
    logic [NUM_MASTERS-1:0]           m_req;
    logic [NUM_MASTERS-1:0]           m_we;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]           m_gnt;
    logic [NUM_MASTERS-1:0]           m_rvalid;
    logic [DATA_WIDTH-1:0]            m_rdata;
    modport master (
        output load_req, load_cen, load_wen, load_a, load_d, m_req, m_we, m_addr, m_wdata,
        input  load_q, load_active, m_gnt, m_rvalid, m_rdata
    );
    modport slave (
        input  load_req, load_cen, load_wen, load_a, load_d, m_req, m_we, m_addr, m_wdata,
        output load_q, load_active, m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/sram_multi_port_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first request at or above ptr, wrapping
module rr_priority_picker
    import sram_multi_port_arbiter_pkg::*;
#(
    parameter int N = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N; i++) w_hi[i] = i_req[i] && (IW'(i) >= i_ptr);
        w_sel = |w_hi ? w_hi : i_req;
        o_gnt = '0;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                o_gnt = N'(1) << i;
                o_idx = IW'(i);
            end
        end
    end
endmodule

// File: rtl/sram_multi_port_arbiter.sv
// sram_multi_port_arbiter: shares one single-port SRAM between a priority loader and
// round-robin processor masters, returning each read to its owner via a tag pipeline
module sram_multi_port_arbiter
    import sram_multi_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_MASTERS = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sram_multi_port_arbiter_if.slave bus,
    output logic                  o_sram_cen,
    output logic                  o_sram_wen,
    output logic [ADDR_WIDTH-1:0] o_sram_a,
    output logic [DATA_WIDTH-1:0] o_sram_d,
    input  logic [DATA_WIDTH-1:0] i_sram_q
);
    localparam int IW = idx_width(NUM_MASTERS);
    localparam int RL = RD_LATENCY;
    state_t                 r_state;
    logic [IW-1:0]          r_ptr;
    logic [RL-1:0]          r_tag_v;
    logic [RL-1:0][IW-1:0]  r_tag_idx;
    logic [NUM_MASTERS-1:0] w_gnt;
    logic [IW-1:0]          w_idx;
    logic [IW-1:0]          w_ptr_nxt;
    logic                   w_issue;
    logic                   w_load;
    logic                   w_push;
    logic                   w_rv;

    rr_priority_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick (
        .i_req(bus.m_req),
        .i_ptr(r_ptr),
        .o_gnt(w_gnt),
        .o_idx(w_idx)
    );

    // Reset overrides everything combinationally so no grant or strobe leaks out while RST is high
    assign w_issue = r_state == ST_ARB && !bus.load_req && !i_rst && |bus.m_req;
    assign w_load = r_state == ST_LOAD && !i_rst;
    assign w_push = w_issue && !bus.m_we[w_idx];
    assign w_rv = r_tag_v[RL-1] && !i_rst;
    assign w_ptr_nxt = (w_idx == IW'(NUM_MASTERS - 1)) ? '0 : w_idx + 1'b1;

    assign bus.m_gnt = w_issue ? w_gnt : '0;
    assign bus.m_rvalid = w_rv ? NUM_MASTERS'(1) << r_tag_idx[RL-1] : '0;
    assign bus.m_rdata = w_rv ? i_sram_q : '0;
    assign bus.load_q = w_load ? i_sram_q : '0;
    assign bus.load_active = w_load;

    assign o_sram_cen = w_load ? bus.load_cen : (w_issue ? SRAM_ACTIVE : SRAM_IDLE);
    assign o_sram_wen = w_load ? bus.load_wen : (w_issue ? !bus.m_we[w_idx] : SRAM_IDLE);
    assign o_sram_a = w_load ? bus.load_a : (w_issue ? bus.m_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0);
    assign o_sram_d = w_load ? bus.load_d : (w_issue ? bus.m_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH] : '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_ARB;
            r_ptr <= '0;
            r_tag_v <= '0;
            r_tag_idx <= '0;
        end else begin
            r_tag_v <= RL'({r_tag_v, w_push});
            r_tag_idx <= (RL*IW)'({r_tag_idx, w_idx});
            if (r_state == ST_ARB) begin
                if (bus.load_req) r_state <= |r_tag_v ? ST_DRAIN : ST_LOAD;
                else if (w_issue) r_ptr <= w_ptr_nxt;
            end else if (r_state == ST_DRAIN) begin
                if (!(|r_tag_v)) r_state <= bus.load_req ? ST_LOAD : ST_ARB;
            end else if (!bus.load_req) begin
                r_state <= ST_ARB;
                r_ptr <= '0;
            end
        end
    end
endmodule

// File: doc/sram_multi_port_arbiter.md
Name: sram_multi_port_arbiter

Overview:
Parametrised successor to the fixed loader/CPU SRAM mux. It shares one single-port SRAM (low-active CEN/WEN, registered Q) between one serial-loader port and NUM_MASTERS processor-side masters (CPU instruction fetch, CPU data, ALU/DMA). The loader has absolute priority. Masters are arbitrated round-robin, one access per cycle. Read-return tags are tracked so each read returns to its owner. The block sits between SRAM_IO_CTRL/SERIAL_CPU_8BIT-class masters and the RA1SHD SRAM macro.

Parameters:
DATA_WIDTH, 8, SRAM word width
ADDR_WIDTH, 9, SRAM address width
NUM_MASTERS, 2, number of arbitrated masters (>=1)
RD_LATENCY, 1, cycles from access cycle (CEN low) to valid SRAM_Q (>=1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active high
LOAD_REQ  in  1  loader requests exclusive SRAM ownership (level)
LOAD_CEN  in  1  loader chip enable, low active
LOAD_WEN  in  1  loader write enable, low active
LOAD_A  in  ADDR_WIDTH  loader address
LOAD_D  in  DATA_WIDTH  loader write data
LOAD_Q  out  DATA_WIDTH  SRAM_Q when LOAD_ACTIVE, else 0
LOAD_ACTIVE  out  1  loader owns SRAM (state LOAD)
M_REQ  in  NUM_MASTERS  per-master access request (level, held until granted)
M_WE  in  NUM_MASTERS  1 = write, 0 = read
M_ADDR  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*AW +: AW]
M_WDATA  in  NUM_MASTERS*DATA_WIDTH  packed write data
M_GNT  out  NUM_MASTERS  one-hot grant; the access is issued in that same cycle
M_RVALID  out  NUM_MASTERS  one-hot, one-cycle read-return strobe
M_RDATA  out  DATA_WIDTH  SRAM_Q when any M_RVALID, else 0
SRAM_CEN  out  1  to macro, low active
SRAM_WEN  out  1  to macro, low active
SRAM_A  out  ADDR_WIDTH  to macro
SRAM_D  out  DATA_WIDTH  to macro
SRAM_Q  in  DATA_WIDTH  from macro

Behaviour:
- States: ARB, DRAIN, LOAD. Reset -> ARB. Reset state of all outputs: M_GNT=0, M_RVALID=0, LOAD_ACTIVE=0, SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0, SRAM_D=0. Round-robin pointer = 0; tag pipeline cleared.
- ARB, LOAD_REQ=0:
  - Grant goes to the first requesting master at index >= ptr, wrapping modulo NUM_MASTERS. M_GNT is combinational from M_REQ/ptr.
  - SRAM_CEN=0, SRAM_WEN=!M_WE[g], SRAM_A/SRAM_D from master g.
  - Next cycle ptr = (g+1) mod NUM_MASTERS.
  - With no requests: SRAM_CEN=1, SRAM_WEN=1, ptr unchanged.
- Read tracking:
  - A granted read pushes {valid, g} into a RD_LATENCY-deep shift pipeline.
  - At pipeline output, M_RVALID[g]=1 and M_RDATA=SRAM_Q, exactly RD_LATENCY cycles after grant.
  - Writes push an invalid tag and produce no strobe.
  - Back-to-back reads are supported at full rate.
- ARB, LOAD_REQ=1: no grant this cycle, even if M_REQ is present. The loader wins simultaneous events. Go to DRAIN if any tag is valid, else to LOAD.
- DRAIN: no grants. SRAM_CEN=1. Outstanding reads still return. Go to LOAD when the pipeline is empty (at most RD_LATENCY cycles).
- DRAIN with LOAD_REQ deasserted: completes the drain, then returns to ARB (not LOAD).
- LOAD:
  - LOAD_ACTIVE=1. SRAM_CEN/WEN/A/D are combinational pass-through of the LOAD_* inputs.
  - M_GNT=0, M_RVALID=0. LOAD_Q=SRAM_Q.
  - On LOAD_REQ=0, return to ARB with ptr reset to 0. LOAD_ACTIVE falls in the same cycle as the transition.
- RST asserted mid-operation: pending read strobes are discarded (never emitted). The state returns to ARB even if LOAD_REQ is held; LOAD is re-entered on the following cycle.
- NUM_MASTERS=1 degenerates to a fixed grant; ptr stays 0.
- A master must hold M_REQ/M_WE/M_ADDR/M_WDATA stable until M_GNT. The arbiter does not buffer requests.

Decomposition:
- Shared package (DEFINE_CPU-style include): state encodings ARB/DRAIN/LOAD, low-active SRAM constants (SRAM_ACTIVE=0, SRAM_IDLE=1), and a clog2 function for the master-index width.
- One sub-module: rr_priority_picker. Inputs are req vector and ptr; outputs are one-hot grant and index. It is purely combinational and reusable for the ALU request arbiter.

Test Plan:
- Reset with M_REQ=2'b11 and LOAD_REQ=0 held -> during reset M_GNT=0, SRAM_CEN=1. First cycle after reset: M_GNT=2'b01. Next cycle: 2'b10. Grants alternate.
- Master 0 reads addr 9'h010 holding 8'hA5 (RD_LATENCY=1) -> exactly one cycle after grant, M_RVALID=2'b01 and M_RDATA=8'hA5. Master 1 sees no strobe.
- Master 1 writes 8'h3C to 9'h1FF, then reads it back -> the write cycle shows SRAM_WEN=0 and no RVALID. The read returns 8'h3C with M_RVALID=2'b10.
- Master 0 read granted, LOAD_REQ rises the next cycle -> the read still returns with M_RVALID=2'b01. LOAD_ACTIVE rises after the drain. Loader writes 8'h77@9'h000 and the SRAM pins follow LOAD_*. M_GNT stays 0 throughout.
- LOAD_REQ and M_REQ=2'b01 rise together -> no grant is issued. LOAD_REQ falls -> ARB resumes with the first grant to master 0 (ptr=0).
- RST pulsed one cycle after a read grant -> no M_RVALID is ever emitted for that read. All outputs return to reset values.
